// File: rtl/iris_class_collector.sv
// Iris output-layer collector: drives the shared Run/En handshake of the three
// output neurons and discards their flush pass. It captures the eval-pass scores,
// resolves the winning class by sequential argmax, and offers it upstream with a
// valid/ack handshake. A per-pass watchdog reports a stalled neuron.
module iris_class_collector #(
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 31
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic signed [DATA_WIDTH+5:0] Y0,
  input  logic signed [DATA_WIDTH+5:0] Y1,
  input  logic signed [DATA_WIDTH+5:0] Y2,
  input  logic                         Ready0,
  input  logic                         Ready1,
  input  logic                         Ready2,
  output logic                         Run,
  output logic                         En,
  output logic                         busy,
  output logic                         valid,
  input  logic                         ack,
  output logic [1:0]                   class_idx,
  output logic signed [DATA_WIDTH+5:0] max_score,
  output logic                         timeout_err
);

  localparam int SW = DATA_WIDTH + 6;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE, FLUSH_PASS, EVAL_PASS, CMP1, CMP2, DONE
  } state_t;

  state_t                 state, state_d;
  logic [2:0]             flags, flags_d;
  logic [CW-1:0]          cnt, cnt_d, cnt_inc;
  logic                   run_d, valid_d, terr_d;
  logic [1:0]             cls_d;
  logic signed [SW-1:0]   max_d;
  logic signed [SW-1:0]   s0, s1, s2, bscore;
  logic [1:0]             best;
  logic [2:0]             seen;
  logic                   all_seen;

  // A Ready pulse counts toward completion in the very cycle it arrives.
  assign seen     = flags | {Ready2, Ready1, Ready0};
  assign all_seen = &seen;
  assign cnt_inc  = cnt + CW'(1);
  assign busy     = (state != IDLE);

  // Next-state and next-output decode; every target defaults to holding.
  always_comb begin
    state_d = state;
    flags_d = flags;
    cnt_d   = cnt;
    run_d   = Run;
    valid_d = valid;
    terr_d  = timeout_err;
    cls_d   = class_idx;
    max_d   = max_score;
    unique case (state)
      IDLE: begin
        if (start) begin
          run_d   = 1'b1;
          flags_d = '0;
          cnt_d   = '0;
          state_d = FLUSH_PASS;
        end
      end
      FLUSH_PASS, EVAL_PASS: begin
        flags_d = seen;
        cnt_d   = cnt_inc;
        if (all_seen) begin
          if (state == FLUSH_PASS) begin
            // Dropping Run sends the neurons into their real evaluation pass.
            run_d   = 1'b0;
            flags_d = '0;
            cnt_d   = '0;
            state_d = EVAL_PASS;
          end else begin
            state_d = CMP1;
          end
        end else if (cnt_inc == TO_LIM) begin
          run_d   = 1'b0;
          cls_d   = '0;
          max_d   = '0;
          terr_d  = 1'b1;
          valid_d = 1'b1;
          state_d = DONE;
        end
      end
      CMP1: state_d = CMP2;
      CMP2: begin
        // Strict compare keeps ties on the lower index.
        if (s2 > bscore) begin
          cls_d = 2'd2;
          max_d = s2;
        end else begin
          cls_d = best;
          max_d = bscore;
        end
        terr_d  = 1'b0;
        valid_d = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (ack) begin
          valid_d = 1'b0;
          terr_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and result registers; En rises on the first clock after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      flags       <= '0;
      cnt         <= '0;
      Run         <= 1'b0;
      En          <= 1'b0;
      valid       <= 1'b0;
      timeout_err <= 1'b0;
      class_idx   <= '0;
      max_score   <= '0;
    end else begin
      state       <= state_d;
      flags       <= flags_d;
      cnt         <= cnt_d;
      Run         <= run_d;
      En          <= 1'b1;
      valid       <= valid_d;
      timeout_err <= terr_d;
      class_idx   <= cls_d;
      max_score   <= max_d;
    end
  end

  // Score capture in the eval pass (latest Y wins), then first argmax step.
  always_ff @(posedge clk) begin
    if (state == EVAL_PASS) begin
      if (Ready0) s0 <= Y0;
      if (Ready1) s1 <= Y1;
      if (Ready2) s2 <= Y2;
    end
    if (state == CMP1) begin
      if (s1 > s0) begin
        best   <= 2'd1;
        bscore <= s1;
      end else begin
        best   <= 2'd0;
        bscore <= s0;
      end
    end
  end

endmodule

// File: tb/tb_iris_class_collector.sv
// Directed bench for iris_class_collector: schedules neuron Ready/Y pulses per
// cycle relative to start, queues expected results and compares them on valid.
module tb_iris_class_collector;

  localparam int DW = 8;
  localparam int SW = DW + 6;
  localparam int TO = 31;

  logic                 clk = 1'b0;
  logic                 rst_n, start, ack;
  logic                 Ready0, Ready1, Ready2;
  logic signed [SW-1:0] Y0, Y1, Y2;
  logic                 Run, En, busy, valid, timeout_err;
  logic [1:0]           class_idx;
  logic signed [SW-1:0] max_score;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    int cls;
    int score;
    int terr;
  } exp_t;
  exp_t sb[$];

  int fr[3];
  int er[3];
  int yv[3];
  bit stray_start;

  always #5 clk = ~clk;

  iris_class_collector #(.DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .Y0(Y0), .Y1(Y1), .Y2(Y2),
    .Ready0(Ready0), .Ready1(Ready1), .Ready2(Ready2),
    .Run(Run), .En(En), .busy(busy), .valid(valid), .ack(ack),
    .class_idx(class_idx), .max_score(max_score), .timeout_err(timeout_err)
  );

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic drive_idle();
    start  = 1'b0;
    Ready0 = 1'b0; Ready1 = 1'b0; Ready2 = 1'b0;
    Y0 = '0; Y1 = '0; Y2 = '0;
  endtask

  // Inputs for cycle k after start; flush-pass Y is -12 and must be discarded.
  task automatic drive(input int k);
    start  = (k == 0) || (stray_start && (k == 3 || k == 10));
    Ready0 = (k == fr[0]) || (k == er[0]);
    Ready1 = (k == fr[1]) || (k == er[1]);
    Ready2 = (k == fr[2]) || (k == er[2]);
    Y0 = (k == er[0]) ? yv[0][SW-1:0] : -12;
    Y1 = (k == er[1]) ? yv[1][SW-1:0] : -12;
    Y2 = (k == er[2]) ? yv[2][SW-1:0] : -12;
  endtask

  // One classification: called right after a negedge with the DUT in IDLE.
  task automatic run_class(input int f0, f1, f2, e0, e1, e2, y0, y1, y2,
                           input int xc, xs, xt, xv, hold, input bit stray);
    bit   got = 1'b0;
    exp_t e;
    fr = '{f0, f1, f2};
    er = '{e0, e1, e2};
    yv = '{y0, y1, y2};
    stray_start = stray;
    e = '{xc, xs, xt};
    check("idle_run_low", Run, 0);
    check("idle_busy_low", busy, 0);
    sb.push_back(e);
    drive(0);
    for (int k = 1; k <= xv + 4 && !got; k++) begin
      @(negedge clk);
      if (k == 1) check("run_high_c1", Run, 1);
      if (k == 9 && f0 == 8 && f1 == 8 && f2 == 8) check("run_low_c9", Run, 0);
      if (stray && (k == 3 || k == 10)) check("busy_on_stray_start", busy, 1);
      if (valid) begin
        got = 1'b1;
        check("valid_cycle", k, xv);
        check("run_low_done", Run, 0);
        if (sb.size() == 0) begin
          check("scoreboard_empty", 0, 1);
        end else begin
          e = sb.pop_front();
          check("class_idx", class_idx, e.cls);
          check("max_score", max_score, e.score);
          check("timeout_err", timeout_err, e.terr);
        end
      end else begin
        drive(k);
      end
    end
    if (!got) begin
      check("valid_never_seen", 0, 1);
      sb.delete();
    end
    drive_idle();
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", valid, 1);
      check("hold_busy", busy, 1);
      check("hold_class", class_idx, e.cls);
      check("hold_score", max_score, e.score);
    end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check("ack_valid_low", valid, 0);
    check("ack_busy_low", busy, 0);
    check("ack_terr_low", timeout_err, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    ack   = 1'b0;
    stray_start = 1'b0;
    drive_idle();
    repeat (2) @(negedge clk);
    check("rst_run", Run, 0);
    check("rst_en", En, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_class", class_idx, 0);
    check("rst_score", max_score, 0);
    check("rst_terr", timeout_err, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("en_after_reset", En, 1);

    // Lockstep neurons, clear winner in class 2.
    run_class(8, 8, 8, 15, 15, 15,   5,  -3,  20,  2,  20, 0, 18, 0, 1'b0);
    // Tie between 0 and 1 resolves to 0.
    run_class(8, 8, 8, 15, 15, 15,   7,   7,  -1,  0,   7, 0, 18, 0, 1'b0);
    // All equal negative scores.
    run_class(8, 8, 8, 15, 15, 15, -40, -40, -40,  0, -40, 0, 18, 0, 1'b0);
    // Skewed eval Ready pulses plus start pulses while busy.
    run_class(8, 8, 8, 13, 15, 17,   1,   9,   4,  1,   9, 0, 20, 0, 1'b1);
    // Neuron 1 never answers: watchdog result.
    run_class(8, -1, 8, 15, -1, 15,  3,   4,   5,  0,   0, 1, TO + 1, 0, 1'b0);
    // Ack withheld for 10 cycles.
    run_class(8, 8, 8, 15, 15, 15,  -5,  30,  30,  1,  30, 0, 18, 10, 1'b0);
    // Start in the first cycle after ack.
    run_class(8, 8, 8, 15, 15, 15, -100, -200, -50, 2, -50, 0, 18, 0, 1'b0);

    // Asynchronous reset during the eval pass.
    fr = '{8, 8, 8};
    er = '{15, 15, 15};
    yv = '{1, 2, 3};
    stray_start = 1'b0;
    drive(0);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      drive(k);
    end
    check("busy_in_eval", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_run", Run, 0);
    check("async_rst_valid", valid, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_en", En, 0);
    @(negedge clk);
    drive_idle();
    rst_n = 1'b1;
    @(negedge clk);
    check("en_after_rerelease", En, 1);
    run_class(8, 8, 8, 15, 15, 15,  13,   0,  -8,  0,  13, 0, 18, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
